// File: rtl/lsu_dm_master.sv
// rtl/lsu_dm_master.sv - load/store unit mastering the 4 KB word-addressed data memory
// Sub-word stores read-modify-write through MERGE; loads extract a byte lane and extend it.
module lsu_dm_master #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MERGE,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_din_q, dm_din_d;

  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_BAD) begin
      req_err = 1'b1;
    end
    if (req_size == SZ_HALF && req_addr[0]) begin
      req_err = 1'b1;
    end
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) begin
      req_err = 1'b1;
    end
    if (|req_addr[31:ADDR_W]) begin
      req_err = 1'b1;
    end
  end

  // Little-endian lane selection from the word currently presented by the memory.
  always_comb begin
    lane_byte = 8'h00;
    case (lane_q)
      2'd0: lane_byte = dm_dout[7:0];
      2'd1: lane_byte = dm_dout[15:8];
      2'd2: lane_byte = dm_dout[23:16];
      2'd3: lane_byte = dm_dout[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = lane_q[1] ? dm_dout[31:16] : dm_dout[15:0];

    load_ext = dm_dout;
    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_ext = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_ext = dm_dout;
    endcase
  end

  always_comb begin
    merged = dm_dout;
    if (size_q == SZ_BYTE) begin
      case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = dm_dout;
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    signed_d  = signed_q;
    lane_d    = lane_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    dm_addr_d = dm_addr_q;
    dm_din_d  = dm_din_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata[15:0];
          rdata_d  = 32'h0;
          err_d    = req_err;
          if (req_err) begin
            // Rejected requests leave the memory-side registers untouched.
            state_d = S_RESP;
          end else begin
            dm_addr_d = {req_addr[31:2], 2'b00};
            if (req_write && req_size == SZ_WORD) begin
              dm_din_d = req_wdata;
              state_d  = S_WRITE;
            end else if (req_write) begin
              state_d = S_MERGE;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_MERGE: begin
        dm_din_d = merged;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      lane_q    <= 2'b00;
      wdata_q   <= 16'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      dm_addr_q <= 32'h0;
      dm_din_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      lane_q    <= lane_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      dm_addr_q <= dm_addr_d;
      dm_din_q  <= dm_din_d;
    end
  end

  // dm_we decodes straight from state so an asynchronous reset drops it at once.
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) & err_q;
  assign rsp_rdata = rdata_q;
  assign dm_we     = (state_q == S_WRITE);
  assign dm_addr   = dm_addr_q;
  assign dm_din    = dm_din_q;

endmodule

// File: tb/tb_lsu_dm_master.sv
// tb/tb_lsu_dm_master.sv - scoreboard bench for lsu_dm_master with a behavioural 4 KB memory
module tb_lsu_dm_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  lsu_dm_master #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  end
  assign dm_dout = mem[dm_addr[11:2]];
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[11:2]] <= dm_din;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   chain = 0;
  int   prev_acc = 0;
  int   prev_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding expectation.
  rsp_t r;
  wr_t  w;
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, r.err});
        chk("rsp_cycle", cyc, r.due);
        chk("ready_in_resp", {31'h0, req_ready}, 32'h0);
      end
    end
    if (!reset && dm_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_dm_we", 32'd1, 32'd0);
      end else begin
        w = wr_q.pop_front();
        chk("dm_addr_wr", dm_addr, w.addr);
        chk("dm_din", dm_din, w.data);
        chk("dm_we_cycle", cyc, w.due);
      end
    end
  end

  // Called at a falling edge; keeps req_valid high so consecutive calls are back-to-back.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic [31:0] exp_mem,
                       input logic exp_err, input int lat);
    int waited = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      return;
    end
    if (chain) chk("accept_spacing", cyc, prev_acc + prev_lat + 1);
    rsp_q.push_back('{exp_rd, exp_err, cyc + lat});
    if (wr && !exp_err) wr_q.push_back('{{a[31:2], 2'b00}, exp_mem, cyc + lat - 1});
    chain = 1;
    prev_acc = cyc;
    prev_lat = lat;
    @(negedge clk);
    chk("ready_low_after_accept", {31'h0, req_ready}, 32'h0);
    if (!exp_err) chk("dm_addr_aligned", dm_addr, {a[31:2], 2'b00});
  endtask

  task automatic go_idle(input int n);
    req_valid = 1'b0;
    chain = 0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int acc;
  int waited;
  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset_dm_addr", dm_addr, 32'h0);
    chk("reset_dm_din", dm_din, 32'h0);
    chk("reset_dm_we", {31'h0, dm_we}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Held req_valid across the whole sequence exercises back-to-back handshakes.
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 0, 2);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 0, 2);
    issue(1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 32'h11223344, 0, 2);
    issue(1, 2'b00, 0, 32'h22, 32'hFFFFFFAA, 32'h0, 32'h11AA3344, 0, 3);
    issue(0, 2'b10, 0, 32'h20, 32'h0, 32'h11AA3344, 32'h0, 0, 2);
    issue(1, 2'b10, 0, 32'h30, 32'h80F7017F, 32'h0, 32'h80F7017F, 0, 2);
    issue(0, 2'b00, 1, 32'h30, 32'h0, 32'h0000007F, 32'h0, 0, 2);
    issue(0, 2'b00, 1, 32'h31, 32'h0, 32'h00000001, 32'h0, 0, 2);
    issue(0, 2'b00, 1, 32'h32, 32'h0, 32'hFFFFFFF7, 32'h0, 0, 2);
    issue(0, 2'b00, 0, 32'h32, 32'h0, 32'h000000F7, 32'h0, 0, 2);
    issue(0, 2'b01, 1, 32'h32, 32'h0, 32'hFFFF80F7, 32'h0, 0, 2);
    issue(0, 2'b01, 0, 32'h32, 32'h0, 32'h000080F7, 32'h0, 0, 2);
    issue(0, 2'b00, 1, 32'h33, 32'h0, 32'hFFFFFF80, 32'h0, 0, 2);
    issue(0, 2'b01, 1, 32'h30, 32'h0, 32'h0000017F, 32'h0, 0, 2);
    issue(0, 2'b10, 1, 32'h30, 32'h0, 32'h80F7017F, 32'h0, 0, 2);
    issue(1, 2'b01, 0, 32'h12, 32'hABCD1234, 32'h0, 32'h1234BEEF, 0, 3);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 32'h0, 0, 2);
    issue(1, 2'b01, 0, 32'h41, 32'h5555, 32'h0, 32'h0, 1, 1);
    issue(1, 2'b10, 0, 32'h42, 32'h5555, 32'h0, 32'h0, 1, 1);
    issue(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 32'h0, 1, 1);
    issue(0, 2'b11, 0, 32'h40, 32'h0, 32'h0, 32'h0, 1, 1);
    issue(0, 2'b10, 0, 32'hFFC, 32'h0, 32'h0, 32'h0, 0, 2);
    go_idle(3);

    // Byte store interrupted by reset while in WRITE: the memory word must survive.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 32'h31;
    req_wdata = 32'h55;
    chk("ready_before_reset_case", {31'h0, req_ready}, 32'h1);
    acc = cyc;
    wr_q.push_back('{32'h30, 32'h80F7557F, acc + 2});
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("dm_we_async_drop", {31'h0, dm_we}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);
    chk("rsp_valid_after_reset", {31'h0, rsp_valid}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("no_rsp_after_reset", {31'h0, rsp_valid}, 32'h0);
    end
    issue(0, 2'b10, 0, 32'h30, 32'h0, 32'h80F7017F, 32'h0, 0, 2);
    go_idle(1);

    waited = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dm_master.md
Name: lsu_dm_master

Overview:
- Load/store unit that initiates accesses to the 4 KB word-addressed data memory (`dm_4k`); it sits between the CPU datapath and the memory.
- Accepts byte, halfword and word load/store requests from the core using a valid/ready handshake.
- Drives the memory's addr/din/MemWrite inputs and consumes its combinational dout.
- Sub-word stores use read-modify-write. Loads are extracted by byte lane and sign- or zero-extended. Misaligned and out-of-range accesses return an error and never touch memory.

Parameters:
- ADDR_W, 12, byte-address width backed by DM (4 KB); any request with req_addr[31:ADDR_W] != 0 is out of range.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  core request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal and returns an error.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the value sits in the low bits for sub-word sizes.
- rsp_valid  output  1  one-cycle pulse, response done.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  qualified by rsp_valid; set for misaligned, out-of-range or illegal size.
- dm_addr  output  32  memory address; always word-aligned (bits[1:0] = 00).
- dm_din  output  32  memory write data.
- dm_we  output  1  memory write enable (MemWrite).
- dm_dout  input  32  memory read data; combinational from dm_addr.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, dm_addr = 0, dm_din = 0, dm_we = 0.
- Reset mid-operation: any pending request is dropped. dm_we falls immediately (asynchronously); no response is issued.
- Byte lanes (little-endian): lane k = addr[1:0] occupies bits [8k+7:8k]. A halfword at addr[1] = h occupies bits [16h+15:16h].
- Request accept: a request is accepted at the rising edge where state == IDLE && req_valid. At that edge, latch write, size, signed, addr and wdata.
- Error check at accept: an error is any of:
  - size == 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 00;
  - addr[31:ADDR_W] != 0.
- States:
  - IDLE: req_ready = 1, dm_we = 0. On accept, go to:
    - RESP with err = 1, on error;
    - WRITE with wbuf = wdata, for a word store;
    - MERGE, for a sub-word store;
    - LOAD, for a load.
  - LOAD: dm_addr = {addr[31:2], 2'b00}. At the edge, capture the selected lane of dm_dout, extend it per size/signed into rdata, then go to RESP.
  - MERGE: dm_addr = aligned address. At the edge, wbuf = dm_dout with the target lane replaced by wdata[7:0] (byte) or wdata[15:0] (half); then go to WRITE.
  - WRITE: dm_we = 1 for exactly one cycle, dm_addr = aligned address, dm_din = wbuf. DM commits at this edge; then go to RESP.
  - RESP: rsp_valid = 1 for one cycle with rsp_rdata and rsp_err; then go to IDLE. req_ready = 0.
- Latency: with N = accept cycle, rsp_valid is high in:
  - cycle N+1 for an error;
  - cycle N+2 for a load or word store;
  - cycle N+3 for a sub-word store.
- Back-to-back: the earliest next accept is the cycle after RESP. req_valid while busy is ignored (the core must hold it).
- Registered vs combinational: dm_addr and dm_din come from registers. dm_we is decoded from state and is never high outside WRITE. Errors produce no dm_we.
- Word-load extension: for word loads, req_signed is ignored.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF.
  - Expect dm_we high exactly one cycle, dm_addr = 0x10, dm_din = 0xDEADBEEF, rsp_valid at N+2.
  - Then a word load at 0x10 returns 0xDEADBEEF at N+2, err = 0.
- Byte store RMW: word at 0x20 holds 0x11223344; store byte 0xAA to 0x22.
  - Expect a MERGE read of 0x20, then dm_din = 0x11AA3344, rsp_valid at N+3.
- Sign/zero extension: word at 0x30 holds 0x80F7017F.
  - lb 0x30 → 0x0000007F.
  - lb 0x31 → 0x00000001.
  - lb 0x32 → 0xFFFFFFF7.
  - lbu 0x32 → 0x000000F7.
  - lh 0x32 → 0xFFFF80F7.
  - lhu 0x32 → 0x000080F7.
- Errors, each giving rsp_err = 1 at N+1, rsp_rdata = 0, dm_we never high:
  - sh to 0x41;
  - sw to 0x42;
  - lw at 0x1000 (ADDR_W = 12);
  - size = 11.
- Handshake: hold req_valid through back-to-back requests.
  - req_ready is low from N+1 until the cycle after RESP.
  - Exactly one rsp_valid pulse per request.
- Reset mid-operation: assert reset during WRITE of a byte store.
  - dm_we drops immediately, no rsp_valid is produced, state is IDLE with req_ready = 1 after release.
